// File: rtl/tmds_link_sequencer_if.sv
// Bundle of the sequencer's link-side signals.
//   pll_lock, retrain          : lock indicator (async) and retrain request
//   video_valid, tmds_video    : encoded words from the TMDS encoders
//   ser_reset, tmds_internal   : reset and data to the OSER10 bank
//   link_up, state, lock_lost_count : status
// master = encoder/control side, slave = the sequencer.
interface tmds_link_sequencer_if #(
  parameter int NUM_CHANNELS = 3
);
  logic                        pll_lock;
  logic                        retrain;
  logic                        video_valid;
  logic [10*NUM_CHANNELS-1:0]  tmds_video;
  logic                        ser_reset;
  logic [10*NUM_CHANNELS-1:0]  tmds_internal;
  logic                        link_up;
  logic [1:0]                  state;
  logic [7:0]                  lock_lost_count;

  modport master (
    output pll_lock, retrain, video_valid, tmds_video,
    input  ser_reset, tmds_internal, link_up, state, lock_lost_count
  );

  modport slave (
    input  pll_lock, retrain, video_valid, tmds_video,
    output ser_reset, tmds_internal, link_up, state, lock_lost_count
  );
endinterface

// File: rtl/tmds_link_sequencer.sv
// Startup / recovery sequencer for the TMDS serializer bank (clk_pixel domain).
// Waits for a filtered PLL lock, holds the serializers in reset, sends control
// symbols for a settle window, then passes encoded video through.
//   clk_pixel : pixel clock
//   reset     : synchronous, active-high
//   bus       : tmds_link_sequencer_if.slave (inputs pll_lock, retrain,
//               video_valid, tmds_video; outputs ser_reset, tmds_internal,
//               link_up, state, lock_lost_count)
module tmds_link_sequencer #(
  parameter int NUM_CHANNELS  = 3,
  parameter int LOCK_FILTER   = 8,
  parameter int RESET_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic                   clk_pixel,
  input  logic                   reset,
  tmds_link_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SER_RST = 2'd1,
    SETTLE  = 2'd2,
    ACTIVE  = 2'd3
  } state_t;

  localparam int FW   = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  // One cycle counter serves both SER_RST and SETTLE; size it for the longer.
  localparam int CMAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] SET_LAST  = CW'(SETTLE_CYCLES - 1);

  state_t          st;
  logic            lock_m, lock_s;
  logic [FW-1:0]   filt_cnt;
  logic [CW-1:0]   cyc_cnt;
  logic [7:0]      lost_cnt;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      lock_m   <= 1'b0;
      lock_s   <= 1'b0;
      st       <= IDLE;
      filt_cnt <= '0;
      cyc_cnt  <= '0;
      lost_cnt <= '0;
    end else begin
      lock_m <= bus.pll_lock;
      lock_s <= lock_m;
      // Lock loss outranks retrain, which outranks the counter transitions.
      if (st != IDLE && !lock_s) begin
        st       <= IDLE;
        filt_cnt <= '0;
        cyc_cnt  <= '0;
        if (lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
      end else if (bus.retrain && (st == SETTLE || st == ACTIVE)) begin
        st      <= SER_RST;
        cyc_cnt <= '0;
      end else begin
        case (st)
          IDLE: begin
            if (!lock_s) filt_cnt <= '0;
            else if (filt_cnt == FILT_LAST) begin
              st       <= SER_RST;
              cyc_cnt  <= '0;
              filt_cnt <= '0;
            end else filt_cnt <= filt_cnt + 1'b1;
          end
          SER_RST: begin
            if (cyc_cnt == RST_LAST) begin
              st      <= SETTLE;
              cyc_cnt <= '0;
            end else cyc_cnt <= cyc_cnt + 1'b1;
          end
          SETTLE: begin
            if (cyc_cnt == SET_LAST) begin
              st      <= ACTIVE;
              cyc_cnt <= '0;
            end else cyc_cnt <= cyc_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Decoded straight from the state register: no added latency.
  assign bus.ser_reset       = (st == IDLE) || (st == SER_RST);
  assign bus.link_up         = (st == ACTIVE);
  assign bus.state           = st;
  assign bus.lock_lost_count = lost_cnt;

  // Per-channel output registers.
  logic                          pass;
  logic [NUM_CHANNELS-1:0][9:0]  video_l, word_l;

  assign pass    = (st == ACTIVE) && bus.video_valid;
  assign video_l = bus.tmds_video;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
    tmds_lane_reg u_lane (
      .clk_pixel (clk_pixel),
      .reset     (reset),
      .pass      (pass),
      .video     (video_l[i]),
      .word      (word_l[i])
    );
  end

  assign bus.tmds_internal = word_l;
endmodule

// One channel's output word: video when passing, otherwise the C1C0=00 control code.
module tmds_lane_reg (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       pass,
  input  logic [9:0] video,
  output logic [9:0] word
);
  localparam logic [9:0] CTRL = 10'b1101010100;

  always_ff @(posedge clk_pixel) begin
    if (reset)     word <= CTRL;
    else if (pass) word <= video;
    else           word <= CTRL;
  end
endmodule
